// File: rtl/skip_monitor.sv
// skip_monitor: counts synchronized SCLK rises per B0 revolution and checks each count against EXP.
// Latency: pin edge to detection is SYNC+1 iCLK cycles; COUNT/VALID/MATCH/LOCK/ERR update at the closing edge.
// Backpressure: none; VALID is a one-cycle strobe with no ready, each revolution overwrites the last result.
//
// Ports: iCLK clock, RST synchronous active-high reset, SCLK/B0 asynchronous ring inputs, EXP expected
// pulses per revolution (sampled at close), CLR clears ERR/LOCK/streak. COUNT/VALID carry the result of the
// last closed revolution; MATCH, LOCK, ERR (sticky) and LOST report pattern health.
module skip_monitor #(
    parameter int unsigned CW    = 8,
    parameter int unsigned SYNC  = 2,
    parameter int unsigned LOCKN = 4,
    parameter int unsigned TOW   = 32,
    parameter int unsigned TMO   = 32'h8000_0000
) (
    input  logic          iCLK,
    input  logic          RST,
    input  logic          SCLK,
    input  logic          B0,
    input  logic [CW-1:0] EXP,
    input  logic          CLR,
    output logic [CW-1:0] COUNT,
    output logic          VALID,
    output logic          MATCH,
    output logic          LOCK,
    output logic          ERR,
    output logic          LOST
);

    localparam int unsigned    SW         = $clog2(LOCKN + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(LOCKN);
    localparam logic [CW-1:0]  CNT_MAX    = '1;
    // Comparing against TMO-1 lets LOST assert on the TMO-th cycle after the last B0 rise.
    localparam logic [TOW-1:0] TMO_LAST   = TOW'(TMO - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SYNC-1:0] sclk_sync_q, b0_sync_q;
    logic            sclk_prev_q, b0_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [TOW-1:0]  tmo_q, tmo_d;
    logic [SW-1:0]   streak_q, streak_d;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q, valid_d;
    logic            match_q, match_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic            lost_q, lost_d;

    logic            rise_s, rise_b0, win_hit;
    logic [CW-1:0]   cnt_start;

    // Both inputs see identical sync + edge-register depth, so their relative alignment is preserved.
    assign rise_s  = sclk_sync_q[SYNC-1] & ~sclk_prev_q;
    assign rise_b0 = b0_sync_q[SYNC-1] & ~b0_prev_q;

    // An SCLK rise coincident with a B0 rise belongs to the window that B0 opens.
    assign cnt_start = {{(CW-1){1'b0}}, rise_s};

    always_ff @(posedge iCLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= '0;
            b0_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            b0_prev_q   <= 1'b0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            tmo_q       <= '0;
            streak_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            lock_q      <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], SCLK};
            b0_sync_q   <= {b0_sync_q[SYNC-2:0], B0};
            sclk_prev_q <= sclk_sync_q[SYNC-1];
            b0_prev_q   <= b0_sync_q[SYNC-1];
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            streak_q    <= streak_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            lost_q      <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (rise_b0) state_d = ST_COUNT;
            ST_COUNT: if (!rise_b0 && (tmo_q == TMO_LAST)) state_d = ST_LOST;
            ST_LOST:  if (rise_b0) state_d = ST_COUNT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        tmo_d    = tmo_q;
        streak_d = streak_q;
        count_d  = count_q;
        valid_d  = 1'b0;
        match_d  = match_q;
        lock_d   = lock_q;
        err_d    = err_q;
        lost_d   = lost_q;
        win_hit  = 1'b0;

        // CLR is applied first so that an error event in the same cycle overrides it.
        if (CLR) begin
            err_d    = 1'b0;
            lock_d   = 1'b0;
            streak_d = '0;
        end

        case (state_q)
            ST_IDLE, ST_LOST: begin
                // Opening edge only: starts a window but reports nothing.
                if (rise_b0) begin
                    cnt_d  = cnt_start;
                    ovf_d  = 1'b0;
                    tmo_d  = '0;
                    lost_d = 1'b0;
                end
            end
            ST_COUNT: begin
                if (rise_b0) begin
                    win_hit = (cnt_q == EXP) && !ovf_q;
                    count_d = cnt_q;
                    valid_d = 1'b1;
                    match_d = win_hit;
                    if (win_hit) begin
                        if (streak_d != STREAK_MAX) streak_d = streak_d + SW'(1);
                        lock_d = (streak_d == STREAK_MAX);
                    end else begin
                        streak_d = '0;
                        lock_d   = 1'b0;
                        err_d    = 1'b1;
                    end
                    cnt_d = cnt_start;
                    ovf_d = 1'b0;
                    tmo_d = '0;
                end else begin
                    if (rise_s) begin
                        if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                        else                  cnt_d = cnt_q + CW'(1);
                    end
                    if (tmo_q == TMO_LAST) begin
                        lost_d   = 1'b1;
                        err_d    = 1'b1;
                        lock_d   = 1'b0;
                        streak_d = '0;
                        match_d  = 1'b0;
                    end else begin
                        tmo_d = tmo_q + TOW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign COUNT = count_q;
    assign VALID = valid_q;
    assign MATCH = match_q;
    assign LOCK  = lock_q;
    assign ERR   = err_q;
    assign LOST  = lost_q;

endmodule

// File: tb/tb_skip_monitor.sv
// tb_skip_monitor: table-driven revolutions with a result scoreboard, plus timeout, overflow and reset sequences.
// Latency: each SCLK slot is two iCLK cycles; a revolution result is expected one revolution after it is driven.
// Backpressure: none; results are popped whenever the monitor sees VALID.
module tb_skip_monitor;

    logic       iCLK = 1'b0;
    logic       RST, SCLK, B0, CLR;
    logic [7:0] EXP;
    logic [3:0] EXP4;
    logic [7:0] COUNT;
    logic       VALID, MATCH, LOCK, ERR, LOST;
    logic [3:0] COUNT4;
    logic       VALID4, MATCH4, LOCK4, ERR4, LOST4;

    always #5 iCLK = ~iCLK;

    skip_monitor #(.CW(8), .SYNC(2), .LOCKN(4), .TOW(32), .TMO(100)) u_dut (
        .iCLK(iCLK), .RST(RST), .SCLK(SCLK), .B0(B0), .EXP(EXP), .CLR(CLR),
        .COUNT(COUNT), .VALID(VALID), .MATCH(MATCH), .LOCK(LOCK), .ERR(ERR), .LOST(LOST)
    );

    skip_monitor #(.CW(4), .SYNC(2), .LOCKN(4), .TOW(32), .TMO(100)) u_c4 (
        .iCLK(iCLK), .RST(RST), .SCLK(SCLK), .B0(B0), .EXP(EXP4), .CLR(CLR),
        .COUNT(COUNT4), .VALID(VALID4), .MATCH(MATCH4), .LOCK(LOCK4), .ERR(ERR4), .LOST(LOST4)
    );

    typedef struct {
        logic [31:0] pat;
        logic [7:0]  exp;
        bit          clr;
        logic [7:0]  e_count;
        bit          e_match;
        bit          e_lock;
        bit          e_err;
    } vec_t;

    typedef struct {
        logic [7:0] count;
        bit         match;
        bit         lock;
        bit         err;
    } res_t;

    vec_t       tbl [15];
    res_t       sb_q [$];
    res_t       sb_r;
    bit         sb_en = 1'b0;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         vcnt = 0;
    logic [7:0] last_count;
    int         c4_vcnt = 0;
    logic [3:0] c4_count;
    bit         c4_match;
    int         v0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // One revolution: slot s pulses SCLK when pat[s] is set; B0 is high for the first half.
    task automatic drive_win(input logic [31:0] pat, input int nslots, input logic [7:0] exp_v, input bit clr);
        for (int s = 0; s < nslots; s++) begin
            if (s == nslots / 2) EXP = exp_v;
            CLR  = clr && (s == nslots / 2 + 1);
            SCLK = pat[s];
            B0   = (s < nslots / 2);
            tick();
            CLR  = 1'b0;
            SCLK = 1'b0;
            tick();
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    always @(negedge iCLK) begin
        if (VALID === 1'b1) begin
            vcnt++;
            last_count = COUNT;
            if (sb_en) begin
                if (sb_q.size() == 0) begin
                    check("valid_unexpected", int'(VALID), 0);
                end else begin
                    sb_r = sb_q.pop_front();
                    check("sb_count", int'(COUNT), int'(sb_r.count));
                    check("sb_match", int'(MATCH), int'(sb_r.match));
                    check("sb_lock",  int'(LOCK),  int'(sb_r.lock));
                    check("sb_err",   int'(ERR),   int'(sb_r.err));
                end
            end
        end
        if (VALID4 === 1'b1) begin
            c4_vcnt++;
            c4_count = COUNT4;
            c4_match = MATCH4;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; SCLK = 1'b0; B0 = 1'b0; CLR = 1'b0; EXP = 8'd8; EXP4 = 4'd15;

        //            pattern        exp   clr   count match lock err
        tbl[0]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{32'h1333, 8'd8, 1'b0, 8'd7, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{32'h3333, 8'd8, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{32'h3333, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{32'h3333, 8'd7, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{32'h6666, 8'd8, 1'b0, 8'd8, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{32'h01FF, 8'd9, 1'b0, 8'd9, 1'b1, 1'b0, 1'b1};

        // Reset state
        tick();
        tick();
        check("rst_count", int'(COUNT), 0);
        check("rst_valid", int'(VALID), 0);
        check("rst_match", int'(MATCH), 0);
        check("rst_lock",  int'(LOCK),  0);
        check("rst_err",   int'(ERR),   0);
        check("rst_lost",  int'(LOST),  0);
        RST = 1'b0;
        vcnt = 0;

        // Table of revolutions; each result is closed by the next revolution's B0 rise.
        sb_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            sb_q.push_back(res_t'{tbl[i].e_count, tbl[i].e_match, tbl[i].e_lock, tbl[i].e_err});
            drive_win(tbl[i].pat, 16, tbl[i].exp, tbl[i].clr);
        end
        drive_win(32'h0, 16, 8'd8, 1'b0);
        sb_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        check("valid_total", vcnt, 15);

        // Timeout: lock, close once more, then hold B0 high with no further rises.
        do_reset();
        for (int i = 0; i < 5; i++) drive_win(32'h3333, 16, 8'd8, 1'b0);
        SCLK = 1'b0;
        B0   = 1'b1;
        for (int k = 1; k <= 103; k++) begin
            tick();
            if (k == 3) begin
                check("tmo_close_valid", int'(VALID), 1);
                check("tmo_close_lock",  int'(LOCK),  1);
            end
            if (k == 102) check("tmo_lost_early", int'(LOST), 0);
            if (k == 103) begin
                check("tmo_lost", int'(LOST), 1);
                check("tmo_err",  int'(ERR),  1);
                check("tmo_lock", int'(LOCK), 0);
            end
        end
        B0 = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        v0 = vcnt;
        drive_win(32'h3333, 16, 8'd8, 1'b0);
        check("resume_lost",     int'(LOST), 0);
        check("resume_no_valid", vcnt, v0);
        drive_win(32'h3333, 16, 8'd8, 1'b0);
        check("resume_valid", vcnt, v0 + 1);
        check("resume_count", int'(last_count), 8);
        check("resume_match", int'(MATCH), 1);
        check("resume_err",   int'(ERR), 1);

        // Overflow on the 4-bit instance: 20 pulses saturate at 15 and cannot match.
        do_reset();
        c4_vcnt = 0;
        EXP4 = 4'd15;
        drive_win(32'h000F_FFFF, 24, 8'd8, 1'b0);
        drive_win(32'h0000_7FFF, 24, 8'd8, 1'b0);
        check("ovf_valid", c4_vcnt, 1);
        check("ovf_count", int'(c4_count), 15);
        check("ovf_match", int'(c4_match), 0);
        check("ovf_err",   int'(ERR4), 1);
        drive_win(32'h0, 24, 8'd8, 1'b0);
        check("full_valid", c4_vcnt, 2);
        check("full_count", int'(c4_count), 15);
        check("full_match", int'(c4_match), 1);
        check("full_err",   int'(ERR4), 1);

        // Reset in the middle of a window after 5 pulses.
        do_reset();
        for (int i = 0; i < 5; i++) drive_win(32'h3333, 16, 8'd8, 1'b0);
        for (int s = 0; s <= 8; s++) begin
            SCLK = s[1] ? 1'b0 : 1'b1;
            B0   = (s < 8);
            tick();
            SCLK = 1'b0;
            tick();
        end
        check("pre_rst_lock", int'(LOCK), 1);
        v0 = vcnt;
        RST = 1'b1;
        tick();
        check("mid_rst_count", int'(COUNT), 0);
        check("mid_rst_valid", int'(VALID), 0);
        check("mid_rst_match", int'(MATCH), 0);
        check("mid_rst_lock",  int'(LOCK),  0);
        check("mid_rst_err",   int'(ERR),   0);
        check("mid_rst_lost",  int'(LOST),  0);
        RST = 1'b0;
        for (int s = 9; s < 16; s++) begin
            SCLK = s[1] ? 1'b0 : 1'b1;
            B0   = 1'b0;
            tick();
            SCLK = 1'b0;
            tick();
        end
        drive_win(32'h3333, 16, 8'd8, 1'b0);
        check("rst_reopen_no_valid", vcnt, v0);
        drive_win(32'h3333, 16, 8'd8, 1'b0);
        check("rst_first_valid", vcnt, v0 + 1);
        check("rst_first_count", int'(last_count), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
